// File: rtl/filter_cfg_ctrl.sv
// Sequences filter reconfiguration: freeze, drain, ROM->coefficient copy, clear, commit mode.
// One button press may be queued while a sequence is running; further presses are dropped.
module filter_cfg_ctrl #(
  parameter int COEF_W    = 16,
  parameter int NUM_TAPS  = 16,
  parameter int TAP_W     = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_next,
  output logic                 o_rom_rd,
  output logic [2+TAP_W-1:0]   o_rom_addr,
  input  logic [COEF_W-1:0]    i_rom_data,
  output logic                 o_coef_we,
  output logic [TAP_W-1:0]     o_coef_addr,
  output logic [COEF_W-1:0]    o_coef_data,
  input  logic                 i_coef_ready,
  output logic                 o_filt_hold,
  output logic                 o_filt_clr,
  output logic [1:0]           o_mode,
  output logic                 o_bypass,
  output logic                 o_busy,
  output logic                 o_cfg_done
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_FETCH, S_WAIT, S_WRITE, S_COMMIT
  } state_t;

  state_t            state;
  logic [1:0]        target;
  logic              pending;
  logic [TAP_W-1:0]  tap;
  logic [DW-1:0]     drain_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      target      <= 2'd0;
      pending     <= 1'b0;
      tap         <= '0;
      drain_cnt   <= '0;
      o_rom_rd    <= 1'b0;
      o_rom_addr  <= '0;
      o_coef_we   <= 1'b0;
      o_coef_addr <= '0;
      o_coef_data <= '0;
      o_filt_hold <= 1'b0;
      o_filt_clr  <= 1'b0;
      o_mode      <= 2'd0;
      o_bypass    <= 1'b1;
      o_busy      <= 1'b0;
      o_cfg_done  <= 1'b0;
    end else begin
      o_rom_rd   <= 1'b0;
      o_filt_clr <= 1'b0;
      o_cfg_done <= 1'b0;

      // Presses arriving mid-sequence (COMMIT included) queue at most one restart.
      if (state != S_IDLE && i_next && !pending)
        pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_next || pending) begin
            target      <= o_mode + 2'd1;
            pending     <= 1'b0;
            drain_cnt   <= '0;
            o_filt_hold <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
            if (target == 2'd0) begin
              o_filt_clr <= 1'b1;
              state      <= S_COMMIT;
            end else begin
              tap        <= '0;
              o_rom_rd   <= 1'b1;
              o_rom_addr <= {target, {TAP_W{1'b0}}};
              state      <= S_FETCH;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        S_FETCH: state <= S_WAIT;

        S_WAIT: begin
          o_coef_we   <= 1'b1;
          o_coef_addr <= tap;
          o_coef_data <= i_rom_data;
          state       <= S_WRITE;
        end

        S_WRITE: begin
          if (i_coef_ready) begin
            o_coef_we <= 1'b0;
            if (tap == TAP_W'(NUM_TAPS - 1)) begin
              o_filt_clr <= 1'b1;
              state      <= S_COMMIT;
            end else begin
              tap        <= tap + TAP_W'(1);
              o_rom_rd   <= 1'b1;
              o_rom_addr <= {target, TAP_W'(tap + TAP_W'(1))};
              state      <= S_FETCH;
            end
          end
        end

        S_COMMIT: begin
          o_mode      <= target;
          o_bypass    <= (target == 2'd0);
          o_cfg_done  <= 1'b1;
          o_filt_hold <= 1'b0;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// Bench for filter_cfg_ctrl: timeline table plus scoreboard of coefficient writes and committed modes.
module tb_filter_cfg_ctrl;
  localparam int COEF_W = 16, NT = 4, TW = 2, DC = 2;

  logic              i_clk = 1'b0, i_rst = 1'b0, i_next = 1'b0, i_coef_ready = 1'b1;
  logic              o_rom_rd, o_coef_we, o_filt_hold, o_filt_clr, o_bypass, o_busy, o_cfg_done;
  logic [2+TW-1:0]   o_rom_addr;
  logic [COEF_W-1:0] i_rom_data = '0, o_coef_data;
  logic [TW-1:0]     o_coef_addr;
  logic [1:0]        o_mode;

  filter_cfg_ctrl #(.COEF_W(COEF_W), .NUM_TAPS(NT), .TAP_W(TW), .DRAIN_CYC(DC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_next(i_next),
    .o_rom_rd(o_rom_rd), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_coef_we(o_coef_we), .o_coef_addr(o_coef_addr), .o_coef_data(o_coef_data),
    .i_coef_ready(i_coef_ready), .o_filt_hold(o_filt_hold), .o_filt_clr(o_filt_clr),
    .o_mode(o_mode), .o_bypass(o_bypass), .o_busy(o_busy), .o_cfg_done(o_cfg_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [TW-1:0] addr; logic [COEF_W-1:0] data; } wr_t;
  typedef struct { int off; logic hold, rd, clr, done, busy; logic [1:0] mode; } tl_t;

  int   checks = 0, errors = 0;
  int   n_acc = 0, n_rd = 0, n_we = 0;
  wr_t  wr_q[$];
  logic [1:0] mode_q[$];
  wr_t  exp_wr;
  logic [1:0] exp_mode;
  logic stall_prev = 1'b0;
  logic [TW-1:0] prev_addr;
  logic [COEF_W-1:0] prev_data;

  function automatic logic [COEF_W-1:0] rom_val(input logic [1:0] m, input logic [TW-1:0] k);
    return {4'hC, m, k, 8'h3C ^ {2'b00, m, 2'b00, k}};
  endfunction

  // ROM model: 1-cycle read latency.
  always @(posedge i_clk) if (o_rom_rd) i_rom_data <= rom_val(o_rom_addr[TW+1:TW], o_rom_addr[TW-1:0]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [1:0] m);
    mode_q.push_back(m);
    if (m != 2'd0)
      for (int k = 0; k < NT; k++) wr_q.push_back({TW'(k), rom_val(m, TW'(k))});
  endtask

  task automatic press();
    @(posedge i_clk); #1 i_next = 1'b1;
    @(posedge i_clk); #1 i_next = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge i_clk); n++; end while (!o_cfg_done && n < 300);
    if (!o_cfg_done) chk({name, "_timeout"}, 1, 0);
  endtask

  // Scoreboard/monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_rom_rd) n_rd++;
      if (o_coef_we) n_we++;
      if (stall_prev) begin
        chk("stall_we", o_coef_we, 1);
        chk("stall_addr", o_coef_addr, prev_addr);
        chk("stall_data", o_coef_data, prev_data);
      end
      stall_prev = o_coef_we && !i_coef_ready;
      prev_addr  = o_coef_addr;
      prev_data  = o_coef_data;
      if (o_coef_we && i_coef_ready) begin
        n_acc++;
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          exp_wr = wr_q.pop_front();
          chk("wr_addr", o_coef_addr, exp_wr.addr);
          chk("wr_data", o_coef_data, exp_wr.data);
        end
      end
      if (o_cfg_done) begin
        if (mode_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_mode = mode_q.pop_front();
          chk("done_mode", o_mode, exp_mode);
          chk("done_bypass", o_bypass, exp_mode == 2'd0);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_mode"}, o_mode, 0);
    chk({pfx, "_bypass"}, o_bypass, 1);
    chk({pfx, "_busy"}, o_busy, 0);
    chk({pfx, "_ctl"}, {o_filt_hold, o_coef_we, o_rom_rd, o_filt_clr, o_cfg_done}, 0);
  endtask

  tl_t tl[7];
  int  cur, n;

  initial begin
    tl[0] = '{1,  1, 0, 0, 0, 1, 0};
    tl[1] = '{2,  1, 0, 0, 0, 1, 0};
    tl[2] = '{3,  1, 1, 0, 0, 1, 0};
    tl[3] = '{4,  1, 0, 0, 0, 1, 0};
    tl[4] = '{15, 1, 0, 1, 0, 1, 0};
    tl[5] = '{16, 0, 0, 0, 1, 0, 1};
    tl[6] = '{17, 0, 0, 0, 0, 0, 1};

    // T1 reset
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk_reset_outputs("t1");

    // T2 timeline from mode 0
    n_acc = 0;
    expect_seq(2'd1);
    press();
    @(negedge i_clk);
    cur = 1;
    for (int i = 0; i < 7; i++) begin
      while (cur < tl[i].off) begin @(negedge i_clk); cur++; end
      chk($sformatf("t2_hold@%0d", tl[i].off), o_filt_hold, tl[i].hold);
      chk($sformatf("t2_rd@%0d", tl[i].off), o_rom_rd, tl[i].rd);
      chk($sformatf("t2_clr@%0d", tl[i].off), o_filt_clr, tl[i].clr);
      chk($sformatf("t2_done@%0d", tl[i].off), o_cfg_done, tl[i].done);
      chk($sformatf("t2_busy@%0d", tl[i].off), o_busy, tl[i].busy);
      chk($sformatf("t2_mode@%0d", tl[i].off), o_mode, tl[i].mode);
    end
    chk("t2_accepts", n_acc, NT);

    // T3 ready stall during tap 2 (mode 1 -> 2)
    n_acc = 0;
    expect_seq(2'd2);
    press();
    n = 0;
    while (!(o_rom_rd && o_rom_addr[TW-1:0] == 2) && n < 100) begin @(negedge i_clk); n++; end
    chk("t3_fetch2_seen", o_rom_rd, 1);
    @(posedge i_clk); #1 i_coef_ready = 1'b0;
    repeat (6) @(posedge i_clk);
    #1 i_coef_ready = 1'b1;
    wait_done("t3");
    chk("t3_accepts", n_acc, NT);
    chk("t3_wr_q_empty", wr_q.size(), 0);

    // T5 mode 3 then bypass
    expect_seq(2'd3);
    press();
    wait_done("t5a");
    n_rd = 0; n_we = 0;
    expect_seq(2'd0);
    press();
    wait_done("t5");
    chk("t5_rom_rd", n_rd, 0);
    chk("t5_coef_we", n_we, 0);
    chk("t5_mode", o_mode, 0);
    chk("t5_bypass", o_bypass, 1);

    // T4 three presses from mode 0: one queued, one dropped
    n_acc = 0;
    expect_seq(2'd1);
    expect_seq(2'd2);
    press();
    repeat (3) @(posedge i_clk);
    press();
    repeat (5) @(posedge i_clk);
    press();
    wait_done("t4a");
    @(negedge i_clk);
    chk("t4_restart_busy", o_busy, 1);
    wait_done("t4b");
    repeat (40) @(negedge i_clk);
    chk("t4_idle", o_busy, 0);
    chk("t4_mode", o_mode, 2);
    chk("t4_accepts", n_acc, 2 * NT);
    chk("t4_mode_q_empty", mode_q.size(), 0);

    // T6 reset during a WRITE stall
    expect_seq(2'd3);
    press();
    #1 i_coef_ready = 1'b0;
    n = 0;
    while (!o_coef_we && n < 100) begin @(negedge i_clk); n++; end
    chk("t6_we_seen", o_coef_we, 1);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk_reset_outputs("t6");
    wr_q.delete();
    mode_q.delete();
    i_coef_ready = 1'b1;
    n_we = 0; n_acc = 0;
    repeat (12) @(negedge i_clk);
    chk("t6_no_we", n_we, 0);
    chk("t6_idle", o_busy, 0);
    expect_seq(2'd1);
    press();
    wait_done("t6_reload");
    chk("t6_accepts", n_acc, NT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
